// File: rtl/uart_rx_baud.sv
`timescale 1ns/1ps
// uart_rx_baud
// -----------------------------------------------------------------------------
// UART receiver (8N1, LSB first) with its own 16x oversampling baud-tick
// generator. The line is sampled at the centre of each bit: a falling edge
// seen in IDLE starts the frame, the START state waits half a bit (8 ticks),
// and each data bit is then taken 16 ticks after the previous sample.
//
// RX is used directly; the caller supplies a synchroniser if the line is
// asynchronous to CLK.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RESET    in   asynchronous, active-high reset
//   RX       in   serial line, idles high
//   TICK     out  oversample strobe, high for one CLK every M clocks
//   RX_DONE  out  one-CLK pulse in the cycle the stop bit completes
//   DOUT     out  shift register contents; valid from the RX_DONE cycle on
//   STATE    out  receiver state: 0 IDLE, 1 START, 2 DATA, 3 STOP
// -----------------------------------------------------------------------------
module uart_rx_baud #(
    parameter int N       = 8,    // divider width, 2**N >= M
    parameter int M       = 163,  // clocks per tick (16 x baud)
    parameter int DBIT    = 8,    // data bits per frame
    parameter int SB_TICK = 16    // ticks spent in the stop bit
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX,
    output logic       TICK,
    output logic       RX_DONE,
    output logic [7:0] DOUT,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [N-1:0] L_CNT_MAX  = N'(M - 1);
    localparam logic [3:0]   L_S_MID    = 4'd7;   // half a bit into the start bit
    localparam logic [3:0]   L_S_LAST   = 4'd15;  // one full bit later
    localparam logic [3:0]   L_SB_LAST  = 4'(SB_TICK - 1);
    localparam logic [2:0]   L_N_LAST   = 3'(DBIT - 1);

    logic [N-1:0] r_cnt;
    logic         w_tick;

    state_t       r_state;
    logic [3:0]   r_s;      // ticks within the current bit
    logic [2:0]   r_n;      // data bits received so far
    logic [7:0]   r_b;      // shift register, fills from the MSB end
    logic         w_done;

    // Free-running baud divider; never gated by the receiver.
    assign w_tick = (r_cnt == L_CNT_MAX);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Receiver FSM. IDLE reacts to RX on every clock so the start edge is
    // caught with one-clock resolution; all other states advance on ticks.
    // Neither the start bit nor the stop bit level is re-checked.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!RX) begin
                        r_state <= ST_START;
                        r_s     <= '0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_s == L_S_MID) begin
                            r_state <= ST_DATA;
                            r_s     <= '0;
                            r_n     <= '0;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_s == L_S_LAST) begin
                            r_s <= '0;
                            r_b <= {RX, r_b[7:1]};
                            if (r_n == L_N_LAST) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_s == L_SB_LAST) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Done is the exit condition of STOP, so it is high for exactly the
    // clock in which the FSM returns to IDLE.
    assign w_done = (r_state == ST_STOP) && w_tick && (r_s == L_SB_LAST);

    assign TICK    = w_tick;
    assign RX_DONE = w_done;
    assign DOUT    = r_b;
    assign STATE   = r_state;

endmodule

// File: tb/tb_uart_rx_baud.sv
`timescale 1ns/1ps
// Bench for uart_rx_baud. The divider is set to M=20, so one bit time is
// 16*20*2 ns = 640 ns; line bit times below are chosen relative to that.
module tb_uart_rx_baud;

  localparam int M_DIV   = 20;
  localparam int BIT_NOM = 642;   // slightly slow, like the 5226 ns case
  localparam int BIT_LO  = 628;   // about -1.9 %
  localparam int BIT_HI  = 652;   // about +1.9 %

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       tick;
  logic       rx_done;
  logic [7:0] dout;
  logic [1:0] state;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  logic [7:0] exp_q[$];
  logic [7:0] trans = 8'h00;     // last four STATE values entered, oldest first
  logic [1:0] prev_state = 2'd0;

  // model: frame progress measured in ticks since the detected falling edge
  int         m_edges = 0;
  bit         m_busy  = 1'b0;
  int         m_k     = 0;
  logic [7:0] m_byte  = 8'h00;

  uart_rx_baud #(.N(8), .M(M_DIV), .DBIT(8), .SB_TICK(16)) dut (
    .CLK     (clk),
    .RESET   (rst),
    .RX      (rx),
    .TICK    (tick),
    .RX_DONE (rx_done),
    .DOUT    (dout),
    .STATE   (state)
  );

  // ---------------- clock ----------------
  always #1 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input int bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      #(bit_ns);
    end
    rx = 1'b1;
    #(bit_ns);
  endtask

  // ---------------- model + per-cycle compare ----------------
  // Start detected at tick 0; data bit j is sampled on tick 24+16*j;
  // the frame ends on tick 152, during which RX_DONE is high.
  initial begin
    bit         e_tick;
    bit         e_done;
    logic [1:0] e_state;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_edges = 0;
        m_busy  = 1'b0;
        m_k     = 0;
        m_byte  = 8'h00;
      end else begin
        if (!m_busy) begin
          if (rx == 1'b0) begin
            m_busy = 1'b1;
            m_k    = 0;
          end
        end else if ((m_edges % M_DIV) == M_DIV - 1) begin
          m_k++;
          if (m_k >= 24 && m_k <= 136 && ((m_k - 8) % 16) == 0)
            m_byte = {rx, m_byte[7:1]};
          if (m_k == 152)
            m_busy = 1'b0;
        end
        m_edges++;
      end
      e_tick  = !rst && ((m_edges % M_DIV) == M_DIV - 1);
      e_done  = m_busy && e_tick && (m_k == 151);
      e_state = !m_busy ? 2'd0 : (m_k < 8) ? 2'd1 : (m_k < 136) ? 2'd2 : 2'd3;
      #0.5;
      chk("tick", tick, e_tick);
      chk("rx_done", rx_done, e_done);
      chk("state", state, e_state);
      chk("dout", dout, m_byte);
      if (state !== prev_state) begin
        trans      = {trans[5:0], state};
        prev_state = state;
      end
      if (rx_done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          chk("frame_byte", dout, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int         cnt;
    logic [7:0] dout_before;

    // reset
    #5;
    chk("rst_state", state, 32'd0);
    chk("rst_dout", dout, 32'h00);
    chk("rst_done", rx_done, 32'd0);
    chk("rst_tick", tick, 32'd0);
    #5 rst = 1'b0;

    // first tick M-1 edges after release, then every M edges, one clock wide
    cnt = 0;
    do begin
      @(posedge clk); #0.5; cnt++;
    end while (tick !== 1'b1 && cnt < 200);
    chk("first_tick_edges", cnt, 32'd19);
    cnt = 0;
    do begin
      @(posedge clk); #0.5; cnt++;
    end while (tick !== 1'b1 && cnt < 200);
    chk("tick_period", cnt, 32'd20);
    @(posedge clk); #0.5;
    chk("tick_width", tick, 32'd0);
    #(110.0 - $realtime);

    // 0x55
    exp_q.push_back(8'h55);
    send_frame(8'h55, BIT_NOM);
    #100;
    chk("state_seq", trans, 32'h6C);
    chk("done_cnt_55", done_cnt, 32'd1);

    // back-to-back 0xA5, 0x00
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    send_frame(8'hA5, BIT_NOM);
    send_frame(8'h00, BIT_NOM);
    #100;
    chk("done_cnt_b2b", done_cnt, 32'd3);

    // reset during data bit 3 of 0xFF
    rx = 1'b0;
    #(BIT_NOM);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      #(BIT_NOM);
    end
    #320;
    rst = 1'b1;
    #0.2;
    chk("abort_state", state, 32'd0);
    chk("abort_dout", dout, 32'h00);
    chk("abort_done", rx_done, 32'd0);
    #9.8;
    rst = 1'b0;
    #(BIT_NOM - 330);
    #(5 * BIT_NOM);
    #100;
    chk("done_cnt_abort", done_cnt, 32'd3);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, BIT_NOM);
    #100;
    chk("done_cnt_3c", done_cnt, 32'd4);
    chk("dout_3c", dout, 32'h3C);

    // baud tolerance
    exp_q.push_back(8'h81);
    send_frame(8'h81, BIT_LO);
    #100;
    chk("done_cnt_slow", done_cnt, 32'd5);
    exp_q.push_back(8'h81);
    send_frame(8'h81, BIT_HI);
    #100;
    chk("done_cnt_fast", done_cnt, 32'd6);
    chk("dout_81", dout, 32'h81);

    // idle line
    dout_before = dout;
    #20000;
    chk("idle_done_cnt", done_cnt, 32'd6);
    chk("idle_state", state, 32'd0);
    chk("idle_dout", dout, dout_before);
    chk("exp_q_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
